// File: rtl/move_seq_pkg.sv
// Shared types for the move sequencer: controller states and the stored move format.
package move_seq_pkg;

    localparam int TORQUE_W = 9;
    localparam int MOVE_W   = 2 * TORQUE_W;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [TORQUE_W-1:0] left;
        logic [TORQUE_W-1:0] right;
    } move_t;

endpackage

// File: rtl/move_sequencer_dwell_timer.sv
// Free-running dwell counter for playback. expire pulses on the last cycle of each
// DWELL_CYCLES window and the count wraps so consecutive moves get equal dwell.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic CLOCK50,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic expire
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             active;

    assign expire = active && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK50) begin
        if (reset || abort) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Records torque moves from SW and plays them back on LEDR, one move per dwell window.
module move_sequencer
    import move_seq_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                    CLOCK50,
    input  logic                    reset,
    input  logic                    save,
    input  logic                    execute,
    input  logic                    clear,
    input  logic                    delete,
    input  logic [MOVE_W-1:0]       SW,
    output logic [MOVE_W-1:0]       LEDR,
    output logic [3:0]              LEDG,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t           state, state_n;
    logic [IDX_W-1:0] index, index_n, index_inc;
    logic [CNT_W-1:0] count_n;
    move_t            ledr, ledr_n;
    logic             done, done_n;
    logic [2:0]       flags;
    logic             wr_en, timer_start, timer_abort, expire;
    move_t            mem [DEPTH];

    assign index_inc = index + IDX_W'(1);
    assign LEDR      = ledr;
    assign LEDG      = {flags, done};

    dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell_timer (
        .CLOCK50 (CLOCK50),
        .reset   (reset),
        .start   (timer_start),
        .abort   (timer_abort),
        .expire  (expire)
    );

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a variable unassigned (no latches).
        state_n     = state;
        count_n     = count;
        index_n     = index;
        ledr_n      = ledr;
        done_n      = done;
        wr_en       = 1'b0;
        timer_start = 1'b0;
        timer_abort = 1'b0;

        if (clear) begin
            state_n     = IDLE;
            count_n     = '0;
            index_n     = '0;
            ledr_n      = '0;
            done_n      = 1'b0;
            timer_abort = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    // Priority is on the raw pulse: a refused execute still masks delete/save.
                    if (execute) begin
                        if (count != '0) begin
                            state_n     = PLAY;
                            index_n     = '0;
                            ledr_n      = mem[0];
                            done_n      = 1'b0;
                            timer_start = 1'b1;
                        end
                    end else if (delete) begin
                        if (count != '0) begin
                            count_n = count - CNT_W'(1);
                            done_n  = 1'b0;
                        end
                    end else if (save) begin
                        if (count != CNT_W'(DEPTH)) begin
                            wr_en   = 1'b1;
                            count_n = count + CNT_W'(1);
                            done_n  = 1'b0;
                        end
                    end
                end
                PLAY: begin
                    if (expire) begin
                        if (CNT_W'(index) + CNT_W'(1) == count) begin
                            state_n     = IDLE;
                            index_n     = '0;
                            ledr_n      = '0;
                            done_n      = 1'b1;
                            timer_abort = 1'b1;
                        end else begin
                            index_n = index_inc;
                            ledr_n  = mem[index_inc];
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK50) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            index <= '0;
            ledr  <= '0;
            done  <= 1'b0;
            flags <= 3'b001;
        end else begin
            state <= state_n;
            count <= count_n;
            index <= index_n;
            ledr  <= ledr_n;
            done  <= done_n;
            flags <= {count_n == CNT_W'(DEPTH), state_n == PLAY, count_n == '0};
        end
    end

    // NOTE: storage has no reset; count gates every read, so stale entries are never shown.
    always_ff @(posedge CLOCK50) begin
        if (wr_en) begin
            mem[count[IDX_W-1:0]] <= move_t'(SW);
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer with DEPTH=4, DWELL_CYCLES=4.
module tb_move_sequencer;

    logic        CLOCK50 = 1'b0;
    logic        reset   = 1'b1;
    logic        save    = 1'b0;
    logic        execute = 1'b0;
    logic        clear   = 1'b0;
    logic        delete  = 1'b0;
    logic [17:0] SW      = '0;
    logic [17:0] LEDR;
    logic [3:0]  LEDG;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [17:0] MA = 18'h3FE01;
    localparam logic [17:0] MB = 18'h00155;
    localparam logic [17:0] MC = 18'h2B3C4;

    move_sequencer #(.DEPTH(4), .DWELL_CYCLES(4)) dut (
        .CLOCK50 (CLOCK50),
        .reset   (reset),
        .save    (save),
        .execute (execute),
        .clear   (clear),
        .delete  (delete),
        .SW      (SW),
        .LEDR    (LEDR),
        .LEDG    (LEDG),
        .count   (count)
    );

    always #10 CLOCK50 = ~CLOCK50;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLOCK50);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic pulse_save(input logic [17:0] v);
        SW = v; save = 1'b1; step(); save = 1'b0;
    endtask

    task automatic pulse_delete();
        delete = 1'b1; step(); delete = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic pulse_execute();
        execute = 1'b1; step(); execute = 1'b0;
    endtask

    // Called one cycle after the execute pulse; checks every dwell cycle, then the idle state.
    task automatic expect_play(input string tag, input int n,
                               input logic [17:0] v0, input logic [17:0] v1,
                               input logic [17:0] v2, input logic [17:0] v3,
                               input logic [3:0] ledg_end);
        logic [17:0] vals [4];
        vals = '{v0, v1, v2, v3};
        for (int e = 0; e < n; e++) begin
            for (int c = 0; c < 4; c++) begin
                check({tag, "_ledr"}, LEDR, vals[e]);
                check({tag, "_busy"}, 18'(LEDG[2]), 18'd1);
                step();
            end
        end
        check({tag, "_end_ledr"}, LEDR, 18'd0);
        check({tag, "_end_ledg"}, 18'(LEDG), 18'(ledg_end));
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_ledr",  LEDR, 18'd0);
        check("rst_ledg",  18'(LEDG), 18'(4'b0010));
        check("rst_count", 18'(count), 18'd0);

        // Single move playback
        pulse_save(18'h30005);
        check("one_count", 18'(count), 18'd1);
        check("one_ledg",  18'(LEDG), 18'(4'b0000));
        pulse_execute();
        expect_play("one_play", 1, 18'h30005, 18'd0, 18'd0, 18'd0, 4'b0001);

        // Fill past capacity: fifth save is dropped
        pulse_clear();
        check("clr_ledg", 18'(LEDG), 18'(4'b0010));
        for (int i = 1; i <= 5; i++) pulse_save(18'(i));
        check("full_count", 18'(count), 18'd4);
        check("full_ledg",  18'(LEDG), 18'(4'b1000));
        pulse_execute();
        expect_play("full_play", 4, 18'd1, 18'd2, 18'd3, 18'd4, 4'b1001);

        // Delete at empty, then delete most recent of three
        pulse_clear();
        pulse_delete();
        check("del_empty_count", 18'(count), 18'd0);
        check("del_empty_ledg",  18'(LEDG), 18'(4'b0010));
        pulse_save(MA);
        pulse_save(MB);
        pulse_save(MC);
        check("abc_count", 18'(count), 18'd3);
        pulse_delete();
        check("del_count", 18'(count), 18'd2);
        pulse_execute();
        expect_play("del_play", 2, MA, MB, 18'd0, 18'd0, 4'b0001);

        // Clear during the second entry
        pulse_execute();
        check("abort_first", LEDR, MA);
        repeat (4) step();
        check("abort_second", LEDR, MB);
        pulse_clear();
        check("abort_ledr",  LEDR, 18'd0);
        check("abort_ledg",  18'(LEDG), 18'(4'b0010));
        check("abort_count", 18'(count), 18'd0);

        // Clear, execute and save together
        pulse_save(MA);
        pulse_save(MB);
        check("combo_pre_count", 18'(count), 18'd2);
        clear = 1'b1; execute = 1'b1; save = 1'b1; SW = MC;
        step();
        clear = 1'b0; execute = 1'b0; save = 1'b0;
        check("combo_count", 18'(count), 18'd0);
        check("combo_ledg",  18'(LEDG), 18'(4'b0010));
        check("combo_ledr",  LEDR, 18'd0);
        step();
        check("combo_idle_ledr", LEDR, 18'd0);
        check("combo_idle_busy", 18'(LEDG[2]), 18'd0);

        // Save/delete ignored during playback, then reset mid-play
        pulse_save(MC);
        pulse_execute();
        check("play_first", LEDR, MC);
        pulse_save(MA);
        pulse_delete();
        check("play_ign_count", 18'(count), 18'd1);
        check("play_ign_ledr",  LEDR, MC);
        check("play_ign_ledg",  18'(LEDG), 18'(4'b0100));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_ledr",  LEDR, 18'd0);
        check("mid_rst_ledg",  18'(LEDG), 18'(4'b0010));
        check("mid_rst_count", 18'(count), 18'd0);
        pulse_execute();
        check("exec_empty_ledg", 18'(LEDG), 18'(4'b0010));
        check("exec_empty_ledr", LEDR, 18'd0);
        repeat (5) step();
        check("exec_empty_late_ledr", LEDR, 18'd0);
        check("exec_empty_late_ledg", 18'(LEDG), 18'(4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, the number of stored moves.
REQ-002 The module SHALL have parameter DWELL_CYCLES, default 50_000_000, the cycles each move is displayed during playback (1 s at 50 MHz).
REQ-003 The module SHALL have port CLOCK50, input, 1 bit, system clock.
REQ-004 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port save, input, 1 bit, single-cycle debounced pulse: store SW as a new move.
REQ-006 The module SHALL have port execute, input, 1 bit, single-cycle pulse: start playback.
REQ-007 The module SHALL have port clear, input, 1 bit, single-cycle pulse: erase all moves and abort playback.
REQ-008 The module SHALL have port delete, input, 1 bit, single-cycle pulse: remove the most recent move.
REQ-009 The module SHALL have port SW, input, 18 bits: [17:9] left torque, [8:0] right torque.
REQ-010 The module SHALL have port LEDR, output, 18 bits: the move being played, same field layout as SW.
REQ-011 The module SHALL have port LEDG, output, 4 bits: [3] full, [2] busy, [1] empty, [0] done.
REQ-012 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored moves.

Function
REQ-013 Control SHALL be a two-state FSM: IDLE and PLAY.
REQ-014 Same-cycle event priority SHALL be clear > execute > delete > save; lower-priority events in that cycle are dropped.
REQ-015 In IDLE, save with count<DEPTH SHALL write SW to mem[count] and increment count on the next edge.
REQ-016 A save with count==DEPTH SHALL be ignored: memory and count unchanged.
REQ-017 In IDLE, delete with count>0 SHALL decrement count; delete with count==0 SHALL be ignored.
REQ-018 clear SHALL set count to 0, force IDLE and LEDR to 0 on the next edge, from either state.
REQ-019 In IDLE, execute with count>0 SHALL enter PLAY with index 0; LEDR SHALL equal mem[0] on the cycle after the pulse.
REQ-020 In IDLE, execute with count==0 SHALL be ignored.
REQ-021 In PLAY, LEDR SHALL hold mem[index] for exactly DWELL_CYCLES cycles, then advance index by 1.
REQ-022 After entry count-1 completes its dwell, the FSM SHALL return to IDLE, drive LEDR to 0 and set done.
REQ-023 In PLAY, save, delete and execute SHALL be ignored.
REQ-024 In IDLE, LEDR SHALL be 0.
REQ-025 LEDG[3] SHALL equal (count==DEPTH), LEDG[2] (state==PLAY) and LEDG[1] (count==0), all registered.
REQ-026 LEDG[0] (done) SHALL clear on any accepted save, delete, clear or execute.
REQ-027 Stored data SHALL be bit-exact; no arithmetic is applied to torque fields.

Reset
REQ-028 Reset SHALL put the FSM in IDLE and set count=0, index=0, dwell counter=0, LEDR=0, done=0, LEDG=4'b0010.
REQ-029 Reset SHALL take priority over all inputs, including during PLAY.
REQ-030 Reset need not clear memory contents; the contents SHALL be unreachable until rewritten.

Structure
REQ-031 Package move_seq_pkg SHALL hold the state enum, TORQUE_W=9, and the move_t packed struct (left, right).
REQ-032 Submodule dwell_timer SHALL implement the DWELL_CYCLES counter, with inputs start and abort, an output expire pulse, and a DWELL_CYCLES parameter.
REQ-033 Move storage SHALL be a register array of DEPTH entries of type move_t.

Verification (bench uses DWELL_CYCLES=4, DEPTH=4)
REQ-034 Save with SW=0x3_0005, then execute: LEDR=0x3_0005 for exactly 4 cycles starting 1 cycle after execute, then LEDR=0, done=1, busy=0.
REQ-035 Five saves of 1..5: count=4, full=1; playback shows 1,2,3,4 for 4 cycles each.
REQ-036 Save A, B, C, delete, execute: playback shows A, B only; delete at count=0 leaves count=0.
REQ-037 Clear during the second PLAY entry: next cycle LEDR=0, busy=0, count=0, empty=1.
REQ-038 Clear+execute+save in the same cycle with count=2: count=0, IDLE, no playback.
REQ-039 Reset asserted mid-PLAY: next cycle all outputs equal reset values; execute with count==0 produces no PLAY.
